// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode map, flag indices and per-opcode flag-update masks
package alu_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;

  // Upper two opcode bits of the address-add and reserved groups
  localparam logic [1:0] OP_ADDR   = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  // Which flag bits an opcode is allowed to overwrite; all others keep their value
  function automatic logic [2:0] flag_mask(input logic [3:0] op);
    logic [2:0] m;
    m = '0;
    case (op)
      OP_ADD, OP_SUB: m = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m[FLAG_Z] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - request/result handshake bundle for alu_pipe
interface alu_pipe_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   opcode;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [2:0]   flags;

  // Issuer / consumer side
  modport master (
    output in_valid, opcode, in1, in2, out_ready,
    input  in_ready, out_valid, result, flags
  );

  // ALU side
  modport slave (
    input  in_valid, opcode, in1, in2, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - combinational ALU datapath producing result and raw Z/V/N
module alu_exec
  import alu_pkg::*;
#(
  parameter int W    = 16,
  parameter int LANE = 4
) (
  input  logic [3:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] result_o,
  output logic         z_o,
  output logic         v_o,
  output logic         n_o
);

  localparam int SW = $clog2(W);
  localparam int NB = W / 8;
  localparam int NL = W / LANE;
  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  logic [SW-1:0]   sh;
  logic [SW:0]     rsh;
  logic [W-1:0]    add_b;
  logic [W-1:0]    sum;
  logic [W-1:0]    sat;
  logic [W-1:0]    rot;
  logic [W-1:0]    red;
  logic [W-1:0]    padd;
  logic            ovf;
  logic [LANE-1:0] la;
  logic [LANE-1:0] lb;
  logic [LANE-1:0] ls;

  // ADD and SUB share one adder: SUB feeds ~in2 with a carry-in of one
  always_comb begin
    add_b = (op_i == OP_SUB) ? ~b_i : b_i;
    sum   = a_i + add_b + W'(op_i == OP_SUB);
    ovf   = (a_i[W-1] == add_b[W-1]) && (sum[W-1] != a_i[W-1]);
    sat   = ovf ? (a_i[W-1] ? SMIN : SMAX) : sum;
  end

  // Rotate right built from two opposing shifts; a zero amount makes the left shift vanish
  always_comb begin
    sh  = b_i[SW-1:0];
    rsh = (SW+1)'(W) - {1'b0, sh};
    rot = (a_i >> sh) | (a_i << rsh);
  end

  // Byte reduction: sign-extend every byte of both operands and accumulate at full width
  always_comb begin
    red = '0;
    for (int i = 0; i < NB; i++) begin
      red = red + {{(W-8){a_i[8*i+7]}}, a_i[8*i +: 8]}
                + {{(W-8){b_i[8*i+7]}}, b_i[8*i +: 8]};
    end
  end

  // Independent signed saturating add in each LANE-bit lane
  always_comb begin
    padd = '0;
    la   = '0;
    lb   = '0;
    ls   = '0;
    for (int l = 0; l < NL; l++) begin
      la = a_i[LANE*l +: LANE];
      lb = b_i[LANE*l +: LANE];
      ls = la + lb;
      if ((la[LANE-1] == lb[LANE-1]) && (ls[LANE-1] != la[LANE-1]))
        padd[LANE*l +: LANE] = la[LANE-1] ? {1'b1, {(LANE-1){1'b0}}}
                                          : {1'b0, {(LANE-1){1'b1}}};
      else
        padd[LANE*l +: LANE] = ls;
    end
  end

  // Opcode select; raw flags are derived from the final (saturated) result
  always_comb begin
    result_o = '0;
    casez (op_i)
      OP_ADD, OP_SUB:  result_o = sat;
      OP_XOR:          result_o = a_i ^ b_i;
      OP_RED:          result_o = red;
      OP_SLL:          result_o = a_i << sh;
      OP_SRA:          result_o = W'($signed(a_i) >>> sh);
      OP_ROR:          result_o = rot;
      OP_PADDSB:       result_o = padd;
      {OP_ADDR, 2'b??}: result_o = a_i + b_i;
      default:         result_o = '0;
    endcase
    z_o = (result_o == '0);
    v_o = ovf;
    n_o = result_o[W-1];
  end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage handshaked ALU with registered result and masked Z/V/N flags
module alu_pipe
  import alu_pkg::*;
#(
  parameter int W    = 16,
  parameter int LANE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  alu_pipe_if.slave  bus
);

  logic         s1_valid_q, s1_valid_d;
  logic [3:0]   s1_op_q,    s1_op_d;
  logic [W-1:0] s1_a_q,     s1_a_d;
  logic [W-1:0] s1_b_q,     s1_b_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] result_q,   result_d;
  logic [2:0]   flags_q,    flags_d;

  logic         s2_load;
  logic         in_ready;
  logic [W-1:0] exec_result;
  logic [2:0]   exec_flags;
  logic [2:0]   mask;

  alu_exec #(.W(W), .LANE(LANE)) u_exec (
    .op_i     (s1_op_q),
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .result_o (exec_result),
    .z_o      (exec_flags[FLAG_Z]),
    .v_o      (exec_flags[FLAG_V]),
    .n_o      (exec_flags[FLAG_N])
  );

  // Stage 2 advances whenever its slot is empty or being drained; stage 1 frees up with it
  always_comb begin
    s2_load  = !out_valid_q || bus.out_ready;
    in_ready = !s1_valid_q || s2_load;
    mask     = flag_mask(s1_op_q);
  end

  // Stage-1 next state: flush wins, otherwise capture on handshake
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (in_ready) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_op_d = bus.opcode;
        s1_a_d  = bus.in1;
        s1_b_d  = bus.in2;
      end
    end
  end

  // Stage-2 next state: result and flags change only when a valid op moves in
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = exec_result;
        flags_d  = (flags_q & ~mask) | (exec_flags & mask);
      end
    end
  end

  // Pipeline registers; reset discards any in-flight op immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe at W=16, LANE=4
module tb_alu_pipe;

  typedef struct packed {
    logic [15:0] res;
    logic [2:0]  raw;
    logic [2:0]  mask;
    logic [15:0] id;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   errors = 0;
  int   checks = 0;
  int   op_id  = 0;
  logic [2:0] model_flags;
  exp_t exp_q[$];

  alu_pipe_if #(.W(16)) bus ();

  alu_pipe #(.W(16), .LANE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int sa, sb, s, sh;
    logic v;
    logic [15:0] r;
    logic signed [7:0] bt;
    logic signed [3:0] x, y;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(b[3:0]);
    v = 1'b0;
    r = '0;
    e.mask = 3'b000;
    case (op)
      4'h0, 4'h1: begin
        s = (op == 4'h0) ? sa + sb : sa - sb;
        v = (s > 32767) || (s < -32768);
        r = v ? ((s > 0) ? 16'h7FFF : 16'h8000) : 16'(s);
        e.mask = 3'b111;
      end
      4'h2: begin r = a ^ b; e.mask = 3'b100; end
      4'h3: begin
        s = 0;
        for (int i = 0; i < 2; i++) begin
          bt = a[8*i +: 8]; s += int'(bt);
          bt = b[8*i +: 8]; s += int'(bt);
        end
        r = 16'(s);
      end
      4'h4: begin r = a << sh; e.mask = 3'b100; end
      4'h5: begin s = sa >>> sh; r = 16'(s); e.mask = 3'b100; end
      4'h6: begin
        r = a;
        for (int i = 0; i < sh; i++) r = {r[0], r[15:1]};
        e.mask = 3'b100;
      end
      4'h7: begin
        for (int l = 0; l < 4; l++) begin
          x = a[4*l +: 4];
          y = b[4*l +: 4];
          s = int'(x) + int'(y);
          if (s > 7) s = 7;
          if (s < -8) s = -8;
          r[4*l +: 4] = 4'(s);
        end
      end
      4'h8, 4'h9, 4'hA, 4'hB: r = a + b;
      default: r = '0;
    endcase
    e.res = r;
    e.raw = {r == 16'h0000, v, r[15]};
    e.id  = 16'(op_id);
    return e;
  endfunction

  // Present one op, wait (bounded) for acceptance, record its expectation; returns #1 after the accept edge
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.in1      = a;
    bus.in2      = b;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 50) begin
        check("send_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk);
    exp_q.push_back(model(op, a, b));
    op_id++;
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1 check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: compare each delivered result against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && !flush && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_output", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        model_flags = (model_flags & ~e.mask) | (e.raw & e.mask);
        check($sformatf("op%0d_result", e.id), 32'(bus.result), 32'(e.res));
        check($sformatf("op%0d_flags", e.id), 32'(bus.flags), 32'(model_flags));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.opcode    = '0;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.out_ready = 1'b1;
    model_flags   = 3'b000;

    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flags", 32'(bus.flags), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Saturating ADD with latency check
    send(4'h0, 16'h7FFF, 16'h0001);
    check("lat_after_accept", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_second_edge", 32'(bus.out_valid), 32'd1);
    drain();

    // SUB saturation then XOR updating Z only
    send(4'h1, 16'h8000, 16'h0001);
    send(4'h2, 16'h1234, 16'h1234);
    drain();
    check("xor_flags_111", 32'(bus.flags), 32'h7);

    // Remaining opcode classes, back to back
    send(4'h7, 16'h7777, 16'h1111);
    send(4'h3, 16'h0102, 16'hFF03);
    send(4'h6, 16'h8001, 16'h0001);
    send(4'h9, 16'hFFFF, 16'h0002);
    send(4'h4, 16'h0001, 16'h0004);
    send(4'h5, 16'h8000, 16'h0003);
    send(4'hC, 16'h1234, 16'h5678);
    drain();
    check("addr_add_value", 32'(model(4'h9, 16'hFFFF, 16'h0002).res), 32'h0001);

    // Backpressure: consumer stalls for four cycles
    bus.out_ready = 1'b0;
    send(4'h0, 16'h0001, 16'h0001);
    send(4'h0, 16'h0002, 16'h0002);
    check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("bp_result_held", 32'(bus.result), 32'h0002);
      check("bp_in_ready_held", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    send(4'h0, 16'h0003, 16'h0003);
    @(negedge clk) check("bp_nogap_2", 32'(bus.out_valid), 32'd1);
    @(negedge clk) check("bp_nogap_3", 32'(bus.out_valid), 32'd1);
    drain();

    // Flush with both stages full
    bus.out_ready = 1'b0;
    send(4'h1, 16'h0003, 16'h0005);
    send(4'h2, 16'h00FF, 16'h0F0F);
    check("fl_s2_valid", 32'(bus.out_valid), 32'd1);
    check("fl_s2_result", 32'(bus.result), 32'hFFFE);
    e = exp_q.pop_front();
    model_flags = (model_flags & ~e.mask) | (e.raw & e.mask);
    check("fl_s2_flags", 32'(bus.flags), 32'(model_flags));
    exp_q.delete();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("fl_out_valid", 32'(bus.out_valid), 32'd0);
    check("fl_in_ready", 32'(bus.in_ready), 32'd1);
    check("fl_flags_kept", 32'(bus.flags), 32'(model_flags));
    check("fl_result_kept", 32'(bus.result), 32'hFFFE);
    @(posedge clk); #1;
    check("fl_stays_empty", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    send(4'h0, 16'h0100, 16'h0200);
    drain();

    // Asynchronous reset between edges with ops in flight
    send(4'h0, 16'h0010, 16'h0020);
    send(4'h2, 16'hAAAA, 16'h5555);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_result", 32'(bus.result), 32'd0);
    check("arst_flags", 32'(bus.flags), 32'd0);
    exp_q.delete();
    model_flags = 3'b000;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send(4'h1, 16'h0005, 16'h0005);
    check("arst_lat_accept", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check("arst_lat_second", 32'(bus.out_valid), 32'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the single-cycle combinational ALU.
- Executes the same opcode set at width W: saturating ADD/SUB, XOR, RED, shifts/rotate, PADDSB and address add.
- Adds valid/ready handshaking with backpressure, a registered Z/V/N flag file with per-opcode update masks, and a synchronous flush.
- Sits between the decode/operand-read stage and writeback in the CPU datapath.

Parameters:
W, 16, datapath width; multiple of 8, minimum 16.
LANE, 4, PADDSB sub-word lane width; must divide W.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous; clears both stage valids.
in_valid  in  1  request valid.
in_ready  out  1  stage 1 can accept.
opcode  in  4  operation select.
in1  in  W  operand A.
in2  in  W  operand B.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
result  out  W  registered result.
flags  out  3  registered [2]Z [1]V [0]N.

Behaviour:
- Reset values: s1_valid=0, out_valid=0, result=0, flags=3'b000.
- Stage 1 captures opcode, in1, in2 when in_valid && in_ready.
  - in_ready = !s1_valid || (s2 will load this cycle).
  - s2 loads when !out_valid || out_ready.
- Stage 2 computes from the stage-1 registers and registers result.
- Latency: exactly 2 cycles from acceptance edge to out_valid with no stalls; throughput 1/cycle.
- Backpressure: while out_valid && !out_ready, result is held stable and s1 holds. in_ready falls only when both stages are full. No drop, no duplication, strict in-order delivery.
- flush has priority over all loads: next edge s1_valid=0 and out_valid=0. Flags and result data are not modified.
- Async reset asserted mid-operation discards all in-flight ops immediately.
- Opcode map (sat = clamp to 2^(W-1)-1 / -2^(W-1) on signed overflow):
  - 0000 ADD sat
  - 0001 SUB sat (in1 + ~in2 + 1)
  - 0010 XOR
  - 0011 RED: signed sum of all W/8 bytes of in1 and in2, sign-extended to W
  - 0100 SLL
  - 0101 SRA
  - 0110 ROR; shift amount = in2[log2(W)-1:0]
  - 0111 PADDSB: independent signed saturating add per LANE-bit lane
  - 10xx address add: plain wrap-around add, no saturation
  - 11xx reserved: result=0, flags unchanged
- Flag update happens on the same edge result loads, and is computed from the final (saturated) result:
  - ADD/SUB update Z, V, N. V = pre-saturation signed overflow. N = result[W-1]. Z = (result==0).
  - XOR, SLL, SRA, ROR update Z only.
  - RED, PADDSB, 10xx and 11xx update no flags.
- Flags reflect the op currently held in the result register.

Decomposition:
- Package alu_pkg: opcode localparams (OP_ADD..OP_PADDSB, OP_ADDR prefix), flag index constants (FLAG_Z=2, FLAG_V=1, FLAG_N=0), and per-opcode flag-update mask function.
- Sub-module alu_exec: purely combinational W-parametrised datapath (adder/sat, shifter, reduction tree, PADDSB lanes) producing result and raw Z/V/N.
- alu_pipe holds handshake, pipeline registers and flag register.

Test Plan (W=16, LANE=4):
- ADD 0x7FFF+0x0001 -> result 0x7FFF, flags Z=0 V=1 N=0, out_valid exactly 2 cycles after accept.
- SUB 0x8000-0x0001 -> 0x8000, V=1 N=1; then XOR 0x1234^0x1234 -> 0x0000, flags 3'b111 (Z set; V, N kept).
- PADDSB 0x7777+0x1111 -> 0x7777; RED in1=0x0102 in2=0xFF03 -> 0x0005; ROR 0x8001 by 1 -> 0xC000; 0x9 address add 0xFFFF+0x0002 -> 0x0001, flags unchanged.
- Backpressure: out_ready=0 for 4 cycles while issuing ADDs 1+1, 2+2, 3+3 back-to-back -> in_ready drops after the 2nd accept. Releasing out_ready yields 0x0002, 0x0004, 0x0006 in order, no gaps at out_ready=1.
- flush asserted with both stages full -> next cycle out_valid=0, in_ready=1, flags unchanged; a subsequent op completes normally.
- rst_n low mid-stream (async, between edges) -> out_valid, result, flags immediately 0. After release, first accepted op appears 2 cycles later.
